mac_vec_acc: RTL and testbench

Parametrised, fully pipelined signed multiply-accumulate unit for vector dot products in the neural-network datapath. It accepts one operand pair per cycle with no back-pressure and runs a multiplier with a configurable stage count. Vectors are delimited by `last_in`: the accumulator restarts automatically on the first element of each vector, and the block reports per-vector completion, element count and sticky overflow. It replaces the fixed 8x8→16 MAC wherever dot products of arbitrary length are accumulated.

---
 rtl/mac_pkg.sv | 32 +++
 rtl/mac_mult_pipe.sv | 50 +++++
 rtl/mac_vec_acc.sv | 218 +++++++++++++++++++++
 tb/tb_mac_vec_acc.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
//   Shared definitions for the vector multiply-accumulate datapath:
//     - default width / stage constants used as parameter defaults,
//     - saturation-limit helpers acc_max(w) / acc_min(w),
//     - the sideband struct that travels alongside the multiplier.
// -----------------------------------------------------------------------------
package mac_pkg;

  localparam int DEF_W_IN        = 8;
  localparam int DEF_W_ACC       = 16;
  localparam int DEF_MULT_STAGES = 6;
  localparam int DEF_CNT_W       = 8;

  // Per-element tag carried next to the multiplier pipeline.
  typedef struct packed {
    logic valid;
    logic last;
  } sb_t;

  // Largest value of a w-bit two's-complement number, returned in 64 bits so
  // callers can slice it down to their own accumulator width.
  function automatic logic signed [63:0] acc_max(input int w);
    acc_max = (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value of a w-bit two's-complement number, in 64 bits.
  function automatic logic signed [63:0] acc_min(input int w);
    acc_min = -(64'sd1 <<< (w - 1));
  endfunction

endpackage : mac_pkg

// File: rtl/mac_mult_pipe.sv
// -----------------------------------------------------------------------------
// mac_mult_pipe
//   Signed W_IN x W_IN -> 2*W_IN multiplier with STAGES-1 register stages
//   behind the product. STAGES=1 gives a purely combinational product.
//   This is the single place where a technology multiplier macro would be
//   swapped in; the behavioural form below retimes cleanly in synthesis.
//
// Ports
//   clk   in   clock (unused when STAGES=1)
//   a_i   in   signed operand, W_IN bits
//   b_i   in   signed operand, W_IN bits
//   p_o   out  signed product, 2*W_IN bits, valid STAGES-1 cycles after a_i/b_i
//
// The pipeline carries no valid bits and no reset: qualification travels in
// the sideband shift register of the instantiating module.
// -----------------------------------------------------------------------------
module mac_mult_pipe #(
  parameter int W_IN   = 8,
  parameter int STAGES = 6
) (
  input  logic                       clk,
  input  logic signed [W_IN-1:0]     a_i,
  input  logic signed [W_IN-1:0]     b_i,
  output logic signed [2*W_IN-1:0]   p_o
);

  logic signed [2*W_IN-1:0] prod_c;

  // Both operands are signed, so they are sign-extended to the 2*W_IN
  // context before multiplying and the full product is exact.
  assign prod_c = a_i * b_i;

  generate
    if (STAGES == 1) begin : g_comb
      assign p_o = prod_c;
    end else begin : g_pipe
      logic signed [2*W_IN-1:0] stage_q [STAGES-1];

      always_ff @(posedge clk) begin
        stage_q[0] <= prod_c;
        for (int i = 1; i < STAGES - 1; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end

      assign p_o = stage_q[STAGES-2];
    end
  endgenerate

endmodule : mac_mult_pipe

// File: rtl/mac_vec_acc.sv
// -----------------------------------------------------------------------------
// mac_vec_acc
//   Fully pipelined signed multiply-accumulate for vector dot products.
//   One operand pair per cycle, no back-pressure. Vectors are delimited by
//   last_in; the accumulator restarts on the first element of every vector
//   and reports completion, element count and a sticky overflow flag.
//
// Handshake: valid_in qualifies a, b and last_in in the cycle it is high;
//   there is no ready, every valid element is accepted. valid_out is a
//   one-cycle pulse per accumulated element, in issue order, exactly
//   MULT_STAGES+2 edges after the edge that sampled the element. done
//   pulses together with valid_out for the element that carried last_in.
//
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   valid_in   in   operand pair valid this cycle
//   a, b       in   signed operands, W_IN bits
//   last_in    in   final element of a vector (ignored without valid_in)
//   f          out  signed running accumulator, W_ACC bits
//   valid_out  out  pulse per accumulated element
//   done       out  pulse on the accumulation of the final element
//   count      out  elements accumulated in the current vector (saturating)
//   overflow   out  sticky signed-overflow flag for the current vector
//
// Configuration
//   MAC_VEC_SAT_EN  defined:   overflowing sums clamp to the W_ACC signed
//                              max/min and accumulation continues from there.
//                   undefined: sums wrap modulo 2^W_ACC.
//                   overflow is flagged identically in both builds.
//
// Pipeline (element sampled at edge N):
//   N                input register (a_q, b_q, in_last_q, in_vld_q)
//   N+1..N+S-1       multiplier internal stages (S = MULT_STAGES)
//   N+S              raw product register, sideband tail
//   N+S+1            sign-extended product register
//   N+S+2            accumulator / outputs
// -----------------------------------------------------------------------------
module mac_vec_acc
  import mac_pkg::*;
#(
  parameter int W_IN        = DEF_W_IN,
  parameter int W_ACC       = DEF_W_ACC,     // must be >= 2*W_IN
  parameter int MULT_STAGES = DEF_MULT_STAGES, // 1..8
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic signed [W_IN-1:0]   a,
  input  logic signed [W_IN-1:0]   b,
  input  logic                     last_in,
  output logic signed [W_ACC-1:0]  f,
  output logic                     valid_out,
  output logic                     done,
  output logic [CNT_W-1:0]         count,
  output logic                     overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Input stage: operands are captured only for valid elements so the
  // multiplier inputs stay quiet through bubbles.
  // ---------------------------------------------------------------------------
  logic signed [W_IN-1:0] a_q;
  logic signed [W_IN-1:0] b_q;
  logic                   in_last_q;
  logic                   in_vld_q;

  always_ff @(posedge clk) begin
    if (valid_in) begin
      a_q       <= a;
      b_q       <= b;
      in_last_q <= last_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_vld_q <= 1'b0;
    end else begin
      in_vld_q <= valid_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Multiplier and product registers
  // ---------------------------------------------------------------------------
  logic signed [2*W_IN-1:0]  mult_p;
  logic signed [2*W_IN-1:0]  mult_q;
  logic signed [W_ACC-1:0]   prod_q;

  mac_mult_pipe #(
    .W_IN   (W_IN),
    .STAGES (MULT_STAGES)
  ) u_mult (
    .clk (clk),
    .a_i (a_q),
    .b_i (b_q),
    .p_o (mult_p)
  );

  always_ff @(posedge clk) begin
    mult_q <= mult_p;
    prod_q <= W_ACC'(mult_q);  // signed cast sign-extends to W_ACC
  end

  // ---------------------------------------------------------------------------
  // Sideband: MULT_STAGES-deep valid/last shift register. Its tail lines up
  // with mult_q; one more register lines it up with prod_q.
  // ---------------------------------------------------------------------------
  sb_t sb_q [MULT_STAGES];
  sb_t prod_sb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MULT_STAGES; i++) begin
        sb_q[i] <= '0;
      end
      prod_sb_q <= '0;
    end else begin
      sb_q[0].valid <= in_vld_q;
      sb_q[0].last  <= in_last_q;
      for (int i = 1; i < MULT_STAGES; i++) begin
        sb_q[i] <= sb_q[i-1];
      end
      prod_sb_q <= sb_q[MULT_STAGES-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulate stage
  // ---------------------------------------------------------------------------
  logic signed [W_ACC-1:0] f_q,      f_d;
  logic                    vo_q,     vo_d;
  logic                    done_q,   done_d;
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  logic                    ovf_q,    ovf_d;
  logic                    first_q,  first_d;

  logic signed [W_ACC-1:0] base_c;
  logic signed [W_ACC-1:0] sum_c;
  logic signed [W_ACC-1:0] acc_c;
  logic                    ovf_c;

`ifdef MAC_VEC_SAT_EN
  localparam logic signed [63:0]      MAX64   = acc_max(W_ACC);
  localparam logic signed [63:0]      MIN64   = acc_min(W_ACC);
  localparam logic signed [W_ACC-1:0] ACC_MAX = MAX64[W_ACC-1:0];
  localparam logic signed [W_ACC-1:0] ACC_MIN = MIN64[W_ACC-1:0];
`endif

  // The first element of a vector adds onto zero rather than the held result.
  assign base_c = first_q ? '0 : f_q;
  assign sum_c  = base_c + prod_q;

  // Signed overflow: operands agree in sign, the wrapped sum does not.
  assign ovf_c = (base_c[W_ACC-1] == prod_q[W_ACC-1]) &&
                 (sum_c[W_ACC-1]  != base_c[W_ACC-1]);

`ifdef MAC_VEC_SAT_EN
  // On overflow both operands share a sign, so the product's sign tells the
  // direction of the overflow.
  assign acc_c = ovf_c ? (prod_q[W_ACC-1] ? ACC_MIN : ACC_MAX) : sum_c;
`else
  assign acc_c = sum_c;
`endif

  always_comb begin
    f_d     = f_q;
    vo_d    = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    first_d = first_q;
    if (prod_sb_q.valid) begin
      f_d     = acc_c;
      vo_d    = 1'b1;
      done_d  = prod_sb_q.last;
      if (first_q) begin
        cnt_d = CNT_ONE;
        ovf_d = ovf_c;
      end else begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        ovf_d = ovf_q | ovf_c;
      end
      // The element after a 'last' starts a fresh vector.
      first_d = prod_sb_q.last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_q     <= '0;
      vo_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      f_q     <= f_d;
      vo_q    <= vo_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      first_q <= first_d;
    end
  end

  assign f         = f_q;
  assign valid_out = vo_q;
  assign done      = done_q;
  assign count     = cnt_q;
  assign overflow  = ovf_q;

endmodule : mac_vec_acc

// File: tb/tb_mac_vec_acc.sv
// -----------------------------------------------------------------------------
// tb_mac_vec_acc
//   Directed scenarios with constant expectations plus a cycle-level
//   reference model (plain integer arithmetic on a queue of issued elements)
//   that checks every output on every cycle once reset has been released.
// -----------------------------------------------------------------------------
module tb_mac_vec_acc;

  localparam int W_IN   = 8;
  localparam int W_ACC  = 16;
  localparam int STAGES = 6;
  localparam int CNT_W  = 8;
  localparam int LAT    = STAGES + 2;
  localparam int ACC_HI = 32767;
  localparam int ACC_LO = -32768;
  localparam int CNT_HI = 255;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic                    valid_in = 1'b0;
  logic signed [W_IN-1:0]  a = '0;
  logic signed [W_IN-1:0]  b = '0;
  logic                    last_in = 1'b0;
  logic signed [W_ACC-1:0] f;
  logic                    valid_out;
  logic                    done;
  logic [CNT_W-1:0]        count;
  logic                    overflow;

  mac_vec_acc #(
    .W_IN        (W_IN),
    .W_ACC       (W_ACC),
    .MULT_STAGES (STAGES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .last_in   (last_in),
    .f         (f),
    .valid_out (valid_out),
    .done      (done),
    .count     (count),
    .overflow  (overflow)
  );

  // {valid_out, done, overflow, count, f}
  logic [26:0] obs;
  assign obs = {valid_out, done, overflow, count, f};

  // ---------------------------------------------------------------------------
  // Scoreboard: issued elements with the edge at which their result is due
  // ---------------------------------------------------------------------------
  typedef struct {
    int a;
    int b;
    bit last;
    int due;
  } elem_t;

  elem_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int last_edge = 0;
  int rst_edge = -1;
  bit mon_en = 1'b0;

  int m_f   = 0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  bit m_first = 1'b1;
  bit m_vo  = 1'b0;
  bit m_done = 1'b0;

  // Reference model: dot-product semantics evaluated when each result is due.
  always @(negedge clk) begin
    if (mon_en) begin
      elem_t e;
      int    s;
      bit    o;
      logic [26:0] mexp;
      if (cyc == rst_edge) begin
        exp_q.delete();
        m_f = 0; m_cnt = 0; m_ovf = 1'b0; m_first = 1'b1;
        m_vo = 1'b0; m_done = 1'b0;
      end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        s = (m_first ? 0 : m_f) + e.a * e.b;
        o = (s > ACC_HI) || (s < ACC_LO);
`ifdef MAC_VEC_SAT_EN
        if (s > ACC_HI) s = ACC_HI;
        else if (s < ACC_LO) s = ACC_LO;
`else
        if (s > ACC_HI) s = s - 65536;
        else if (s < ACC_LO) s = s + 65536;
`endif
        m_cnt   = m_first ? 1 : ((m_cnt < CNT_HI) ? m_cnt + 1 : CNT_HI);
        m_ovf   = m_first ? o : (m_ovf | o);
        m_f     = s;
        m_first = e.last;
        m_vo    = 1'b1;
        m_done  = e.last;
      end else begin
        m_vo   = 1'b0;
        m_done = 1'b0;
      end
      mexp = {m_vo, m_done, m_ovf, 8'(m_cnt), 16'(m_f)};
      n_cmp++;
      if (obs !== mexp) begin
        n_err++;
        $display("FAIL model cyc=%0d got vo=%b done=%b ovf=%b cnt=%0d f=%0d exp vo=%b done=%b ovf=%b cnt=%0d f=%0d",
                 cyc, obs[26], obs[25], obs[24], obs[23:16], $signed(obs[15:0]),
                 mexp[26], mexp[25], mexp[24], mexp[23:16], $signed(mexp[15:0]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input int av, input int bv, input bit lv);
    elem_t e;
    @(negedge clk);
    valid_in = 1'b1;
    a        = W_IN'(av);
    b        = W_IN'(bv);
    last_in  = lv;
    last_edge = cyc + 1;
    e.a = av; e.b = bv; e.last = lv; e.due = cyc + 1 + LAT;
    exp_q.push_back(e);
  endtask

  // Idle cycles carry random junk on a/b/last_in, all of which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      a        = W_IN'($urandom_range(0, 255));
      b        = W_IN'($urandom_range(0, 255));
      last_in  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    valid_in = 1'b0;
    rst_edge = cyc + 1;
    @(negedge clk);
    reset    = 1'b0;
  endtask

  function automatic int rnd_op();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== 27'd0) begin
      n_err++;
      $display("FAIL reset_state got=%h exp=%h", obs, 27'd0);
    end
  endtask

  task automatic test_basic();
    int n0;
    logic [26:0] ev[3];
    ev[0] = {1'b1, 1'b0, 1'b0, 8'd1, 16'(12)};
    ev[1] = {1'b1, 1'b0, 1'b0, 8'd2, 16'(2)};
    ev[2] = {1'b1, 1'b1, 1'b0, 8'd3, 16'(51)};
    drive(3, 4, 1'b0);
    n0 = last_edge;
    drive(-2, 5, 1'b0);
    drive(7, 7, 1'b1);
    idle(1);
    wait_edge(n0 + LAT - 1);
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL basic_early got=%b exp=0", valid_out);
    end
    for (int i = 0; i < 3; i++) begin
      wait_edge(n0 + LAT + i);
      n_cmp++;
      if (obs !== ev[i]) begin
        n_err++;
        $display("FAIL basic[%0d] got=%h exp=%h", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    logic [26:0] ev[3];
    ev[0] = {1'b1, 1'b1, 1'b0, 8'd1, 16'(1)};
    ev[1] = {1'b1, 1'b0, 1'b0, 8'd1, 16'(6)};
    ev[2] = {1'b1, 1'b1, 1'b0, 8'd2, 16'(6)};
    drive(1, 1, 1'b1);
    n0 = last_edge;
    drive(2, 3, 1'b0);
    drive(0, 9, 1'b1);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      wait_edge(n0 + LAT + i);
      n_cmp++;
      if (obs !== ev[i]) begin
        n_err++;
        $display("FAIL b2b[%0d] got=%h exp=%h", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_bubbles();
    int n0;
    logic [26:0] ev[5];
    ev[0] = {1'b1, 1'b0, 1'b0, 8'd1, 16'(25)};
    ev[1] = {1'b0, 1'b0, 1'b0, 8'd1, 16'(25)};
    ev[2] = ev[1];
    ev[3] = ev[1];
    ev[4] = {1'b1, 1'b1, 1'b0, 8'd2, 16'(26)};
    drive(5, 5, 1'b0);
    n0 = last_edge;
    idle(3);
    drive(-1, -1, 1'b1);
    idle(1);
    for (int i = 0; i < 5; i++) begin
      wait_edge(n0 + LAT + i);
      n_cmp++;
      if (obs !== ev[i]) begin
        n_err++;
        $display("FAIL bubbles[%0d] got=%h exp=%h", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int n0;
    logic [26:0] ev[4];
    ev[0] = {1'b1, 1'b0, 1'b0, 8'd1, 16'(16129)};
    ev[1] = {1'b1, 1'b0, 1'b0, 8'd2, 16'(32258)};
`ifdef MAC_VEC_SAT_EN
    ev[2] = {1'b1, 1'b1, 1'b1, 8'd3, 16'(32767)};
`else
    ev[2] = {1'b1, 1'b1, 1'b1, 8'd3, 16'(-17149)};
`endif
    ev[3] = {1'b1, 1'b1, 1'b0, 8'd1, 16'(1)};
    drive(127, 127, 1'b0);
    n0 = last_edge;
    drive(127, 127, 1'b0);
    drive(127, 127, 1'b1);
    drive(1, 1, 1'b1);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      wait_edge(n0 + LAT + i);
      n_cmp++;
      if (obs !== ev[i]) begin
        n_err++;
        $display("FAIL overflow[%0d] got=%h exp=%h", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_neg_extremes();
    int n0;
    logic [26:0] ev[2];
    ev[0] = {1'b1, 1'b0, 1'b0, 8'd1, 16'(16384)};
    ev[1] = {1'b1, 1'b1, 1'b0, 8'd2, 16'(128)};
    drive(-128, -128, 1'b0);
    n0 = last_edge;
    drive(-128, 127, 1'b1);
    idle(1);
    for (int i = 0; i < 2; i++) begin
      wait_edge(n0 + LAT + i);
      n_cmp++;
      if (obs !== ev[i]) begin
        n_err++;
        $display("FAIL negext[%0d] got=%h exp=%h", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n1;
    logic [26:0] ev;
    for (int i = 0; i < 4; i++) drive(rnd_op(), rnd_op(), 1'b0);
    idle(1);
    do_reset();
    // Now at the negedge following the reset edge.
    n_cmp++;
    if (obs !== 27'd0) begin
      n_err++;
      $display("FAIL rst_mid_state got=%h exp=%h", obs, 27'd0);
    end
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (valid_out !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid_discard[%0d] got=%b exp=0", i, valid_out);
      end
    end
    ev = {1'b1, 1'b1, 1'b0, 8'd1, 16'(-42)};
    drive(6, -7, 1'b1);
    n1 = last_edge;
    idle(1);
    wait_edge(n1 + LAT);
    n_cmp++;
    if (obs !== ev) begin
      n_err++;
      $display("FAIL rst_mid_restart got=%h exp=%h", obs, ev);
    end
  endtask

  task automatic test_count_sat();
    int nl;
    logic [26:0] ev;
    ev = {1'b1, 1'b1, 1'b0, 8'd255, 16'(258)};
    for (int i = 0; i < 258; i++) drive(1, 1, i == 257);
    nl = last_edge;
    idle(1);
    wait_edge(nl + LAT);
    n_cmp++;
    if (obs !== ev) begin
      n_err++;
      $display("FAIL count_sat got=%h exp=%h", obs, ev);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      drive(rnd_op(), rnd_op(), $urandom_range(0, 5) == 0);
    end
    drive(rnd_op(), rnd_op(), 1'b1);
    idle(LAT + 4);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL random_drain got=%0d pending exp=0", exp_q.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_bubbles();
    test_overflow();
    test_neg_extremes();
    test_reset_mid();
    test_count_sat();
    test_random();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mac_vec_acc
